// File: rtl/ctrl_seq_if.sv
// Instruction/address bundle between an instruction source and ctrl_seq.
// Source drives i_valid/value; the sequencer returns ready, issued address and status.
interface ctrl_seq_if #(
    parameter int ADDRESS_BITS = 5,
    parameter int INSTR_BITS   = 3
);
    localparam int VALUE_BITS = INSTR_BITS + ADDRESS_BITS;

    logic                    i_valid;
    logic                    i_ready;
    logic [VALUE_BITS-1:0]   value;
    logic [ADDRESS_BITS-1:0] o_address;
    logic                    o_strobe;
    logic                    o_busy;
    logic                    o_error;

    modport master (
        output i_valid, value,
        input  i_ready, o_address, o_strobe, o_busy, o_error
    );

    modport slave (
        input  i_valid, value,
        output i_ready, o_address, o_strobe, o_busy, o_error
    );
endinterface

// File: rtl/ctrl_seq.sv
// Line-address sequencer: decodes SET/INC/DEC/BURST/WAIT instructions into strobed addresses.
// Latency: an issued address and its strobe appear the cycle after the accepting edge.
// Backpressure: i_ready is low for the whole of a BURST or WAIT; the source holds its word.
module ctrl_seq #(
    parameter int ADDRESS_BITS = 5,
    parameter int INSTR_BITS   = 3
) (
    input  logic        clk,
    input  logic        rst,
    ctrl_seq_if.slave   bus
);
    localparam int VALUE_BITS = INSTR_BITS + ADDRESS_BITS;

    localparam logic [INSTR_BITS-1:0]   OP_NOP   = INSTR_BITS'(0);
    localparam logic [INSTR_BITS-1:0]   OP_SET   = INSTR_BITS'(1);
    localparam logic [INSTR_BITS-1:0]   OP_INC   = INSTR_BITS'(2);
    localparam logic [INSTR_BITS-1:0]   OP_DEC   = INSTR_BITS'(3);
    localparam logic [INSTR_BITS-1:0]   OP_BURST = INSTR_BITS'(4);
    localparam logic [INSTR_BITS-1:0]   OP_WAIT  = INSTR_BITS'(5);
    localparam logic [ADDRESS_BITS-1:0] ONE      = ADDRESS_BITS'(1);
    localparam logic [ADDRESS_BITS-1:0] ZERO     = '0;

    typedef enum logic [1:0] {
        IDLE,
        BURST,
        WAIT
    } state_t;

    state_t                  state, state_nxt;
    logic [ADDRESS_BITS-1:0] addr_q, addr_nxt;
    logic [ADDRESS_BITS-1:0] cnt_q, cnt_nxt;
    logic                    strobe_q, strobe_nxt;
    logic                    error_q, error_nxt;

    logic [INSTR_BITS-1:0]   opcode;
    logic [ADDRESS_BITS-1:0] operand;
    logic                    accept;

    assign opcode  = bus.value[VALUE_BITS-1:ADDRESS_BITS];
    assign operand = bus.value[ADDRESS_BITS-1:0];
    assign accept  = bus.i_valid && (state == IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            addr_q   <= '0;
            cnt_q    <= '0;
            strobe_q <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state    <= state_nxt;
            addr_q   <= addr_nxt;
            cnt_q    <= cnt_nxt;
            strobe_q <= strobe_nxt;
            error_q  <= error_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        addr_nxt   = addr_q;
        cnt_nxt    = cnt_q;
        strobe_nxt = 1'b0;
        error_nxt  = error_q;
        case (state)
            IDLE: begin
                if (accept) begin
                    case (opcode)
                        OP_NOP: ;
                        OP_SET: begin
                            addr_nxt   = operand;
                            strobe_nxt = 1'b1;
                        end
                        OP_INC: begin
                            addr_nxt   = addr_q + operand;
                            strobe_nxt = 1'b1;
                        end
                        OP_DEC: begin
                            addr_nxt   = addr_q - operand;
                            strobe_nxt = 1'b1;
                        end
                        OP_BURST: begin
                            // First issued address is the current one, so no increment here.
                            state_nxt  = BURST;
                            cnt_nxt    = operand;
                            strobe_nxt = 1'b1;
                        end
                        OP_WAIT: begin
                            if (operand != ZERO) begin
                                state_nxt = WAIT;
                                cnt_nxt   = operand - ONE;
                            end
                        end
                        default: error_nxt = 1'b1;
                    endcase
                end
            end
            BURST: begin
                if (cnt_q == ZERO) begin
                    state_nxt = IDLE;
                end else begin
                    addr_nxt   = addr_q + ONE;
                    cnt_nxt    = cnt_q - ONE;
                    strobe_nxt = 1'b1;
                end
            end
            WAIT: begin
                if (cnt_q == ZERO) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt_q - ONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.i_ready   = (state == IDLE);
    assign bus.o_busy    = (state != IDLE);
    assign bus.o_address = addr_q;
    assign bus.o_strobe  = strobe_q;
    assign bus.o_error   = error_q;
endmodule

// File: tb/tb_ctrl_seq.sv
// Bench for ctrl_seq: directed scenarios then random instructions against a queue-based model.
module tb_ctrl_seq;
    localparam int AB  = 5;
    localparam int IB  = 3;
    localparam int MOD = 1 << AB;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ctrl_seq_if #(.ADDRESS_BITS(AB), .INSTR_BITS(IB)) bus ();

    ctrl_seq #(.ADDRESS_BITS(AB), .INSTR_BITS(IB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Model: expected addresses still to be issued, cycles of stall left, resting address.
    int q[$];
    int m_addr;
    int m_stall;
    bit m_err;
    bit cur_strobe;
    int cur_addr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ins(input int op, input int opr);
        return {op[2:0], opr[4:0]};
    endfunction

    task automatic model_reset();
        q.delete();
        m_addr     = 0;
        m_stall    = 0;
        m_err      = 1'b0;
        cur_strobe = 1'b0;
        cur_addr   = 0;
    endtask

    task automatic model_edge(input logic v, input logic [7:0] val);
        int op, opr;
        op  = int'(val[7:5]);
        opr = int'(val[4:0]);
        if (rst) return;
        if (m_stall > 0) begin
            m_stall--;
        end else if (v) begin
            case (op)
                0: ;
                1: q.push_back(opr);
                2: q.push_back((m_addr + opr) % MOD);
                3: q.push_back((m_addr - opr + MOD) % MOD);
                4: begin
                    for (int i = 0; i <= opr; i++) q.push_back((m_addr + i) % MOD);
                    m_stall = opr + 1;
                end
                5: m_stall = opr;
                default: m_err = 1'b1;
            endcase
        end
        if (q.size() > 0) begin
            cur_strobe = 1'b1;
            cur_addr   = q.pop_front();
            m_addr     = cur_addr;
        end else begin
            cur_strobe = 1'b0;
            cur_addr   = m_addr;
        end
    endtask

    task automatic compare();
        chk("i_ready",   32'(bus.i_ready),   32'(m_stall == 0));
        chk("o_busy",    32'(bus.o_busy),    32'(m_stall != 0));
        chk("o_strobe",  32'(bus.o_strobe),  32'(cur_strobe));
        chk("o_address", 32'(bus.o_address), 32'(cur_addr));
        chk("o_error",   32'(bus.o_error),   32'(m_err));
    endtask

    // Called at a falling edge; drives, crosses one rising edge, checks at the next falling edge.
    task automatic step(input logic v, input logic [7:0] val);
        bus.i_valid = v;
        bus.value   = val;
        @(posedge clk);
        model_edge(v, val);
        @(negedge clk);
        compare();
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        bus.i_valid = 1'b0;
        model_reset();
        #1;
        compare();
        @(posedge clk);
        @(negedge clk);
        compare();
        rst = 1'b0;
    endtask

    initial begin
        bus.i_valid = 1'b0;
        bus.value   = '0;
        model_reset();
        @(negedge clk);
        compare();
        chk("reset_ready", 32'(bus.i_ready), 32'd1);
        chk("reset_addr",  32'(bus.o_address), 32'd0);
        rst = 1'b0;

        // SET 7, INC 3, DEC 12 back-to-back
        step(1'b1, ins(1, 7));
        chk("seq_a_addr", 32'(bus.o_address), 32'd7);
        step(1'b1, ins(2, 3));
        chk("seq_b_addr", 32'(bus.o_address), 32'd10);
        step(1'b1, ins(3, 12));
        chk("seq_c_addr", 32'(bus.o_address), 32'd30);
        chk("seq_c_strb", 32'(bus.o_strobe), 32'd1);
        step(1'b0, ins(0, 0));
        chk("seq_idle_strb", 32'(bus.o_strobe), 32'd0);

        // SET 30 then BURST 3 wrapping through zero
        step(1'b1, ins(1, 30));
        step(1'b1, ins(4, 3));
        chk("burst_first", 32'(bus.o_address), 32'd30);
        for (int i = 0; i < 3; i++) step(1'b0, ins(0, 0));
        chk("burst_last", 32'(bus.o_address), 32'd1);
        chk("burst_last_ready", 32'(bus.i_ready), 32'd0);
        step(1'b0, ins(0, 0));
        chk("burst_done_strb", 32'(bus.o_strobe), 32'd0);
        chk("burst_done_addr", 32'(bus.o_address), 32'd1);

        // WAIT 5 then SET 2 held valid
        step(1'b1, ins(5, 5));
        for (int i = 0; i < 5; i++) step(1'b1, ins(1, 2));
        chk("wait_ready_back", 32'(bus.i_ready), 32'd1);
        chk("wait_no_strb", 32'(bus.o_strobe), 32'd0);
        step(1'b1, ins(1, 2));
        chk("wait_set_addr", 32'(bus.o_address), 32'd2);
        chk("wait_set_strb", 32'(bus.o_strobe), 32'd1);

        // WAIT 0 is a no-op; SET 4 goes straight in
        step(1'b1, ins(5, 0));
        chk("wait0_ready", 32'(bus.i_ready), 32'd1);
        step(1'b1, ins(1, 4));
        chk("wait0_set", 32'(bus.o_address), 32'd4);

        // Illegal opcode is sticky
        step(1'b1, ins(6, 9));
        chk("illegal_err", 32'(bus.o_error), 32'd1);
        chk("illegal_addr", 32'(bus.o_address), 32'd4);
        step(1'b1, ins(1, 1));
        chk("illegal_err_hold", 32'(bus.o_error), 32'd1);
        chk("illegal_set1", 32'(bus.o_address), 32'd1);

        // BURST 20 aborted by reset after the third strobe
        step(1'b1, ins(4, 20));
        step(1'b0, ins(0, 0));
        step(1'b0, ins(0, 0));
        do_reset();
        chk("abort_err", 32'(bus.o_error), 32'd0);
        chk("abort_addr", 32'(bus.o_address), 32'd0);
        for (int i = 0; i < 6; i++) step(1'b0, ins(0, 0));
        chk("abort_quiet", 32'(bus.o_strobe), 32'd0);

        // Random instructions, opcodes weighted toward the legal ones, occasional reset
        for (int i = 0; i < 600; i++) begin
            int op, opr;
            op  = ($urandom_range(0, 9) == 0) ? $urandom_range(6, 7) : $urandom_range(0, 5);
            opr = (op >= 4) ? $urandom_range(0, 6) : $urandom_range(0, MOD - 1);
            if ($urandom_range(0, 79) == 0) do_reset();
            else step(1'($urandom_range(0, 3) != 0), ins(op, opr));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
